pivota_order_scheduler: RTL and testbench
=========================================

// Module: pivota_order_scheduler
// PURPOSE
//  Collects buy/sell orders from NUM_SRC strategy engines and arbitrates them round-robin.
//  Buffers accepted orders in a FIFO and issues them one at a time to the exchange port.
//  Enforces a minimum gap between issued orders and tracks net position (buy +qty, sell -qty).
//  Sits between the compiled strategy blocks and the order-entry interface.
// PARAMETERS
//  NUM_SRC    2     number of requesting strategy engines (1..8)
//  DEPTH      16    FIFO entries (power of 2)
//  MIN_GAP    3     idle cycles enforced after each issued order (0 = back-to-back)
//  POS_LIMIT  64    |net_pos| bound, used only with PIVOTA_POS_LIMIT_EN
// PORTS
//  clk           in   1               clock, rising edge
//  rst_n         in   1               asynchronous, active-low reset
//  src_valid     in   NUM_SRC         per-source order valid
//  src_ready     out  NUM_SRC         per-source accept (one-hot or zero)
//  src_side      in   4*NUM_SRC       per-source side: 1=buy, 2=sell, others illegal
//  src_qty       in   4*NUM_SRC       per-source quantity
//  ord_valid     out  1               order available to exchange
//  ord_ready     in   1               exchange accepts order
//  ord_side      out  4               issued side
//  ord_qty       out  4               issued quantity
//  ord_src       out  $clog2(NUM_SRC) originating source index (width min 1)
//  net_pos       out  16 signed       running net position of accepted orders
//  fifo_count    out  $clog2(DEPTH)+1 occupied entries
//  drop_pulse    out  1               1-cycle pulse: illegal side accepted and discarded
//  reject_pulse  out  1               1-cycle pulse: position-limit reject (0 if macro off)
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty, rr pointer 0, gap counter 0, FSM IDLE.
//  Arbiter: each cycle, if fifo_count < DEPTH (registered), grant the first valid source at/after rr_ptr.
//  - src_ready[g] = 1 only for the granted source. Transfer = src_valid[g] & src_ready[g].
//  - After a transfer, rr_ptr <= g+1 mod NUM_SRC. Without a transfer, rr_ptr holds.
//  - Full FIFO: no src_ready, even if a dequeue occurs in the same cycle.
//  Side check at transfer:
//  - side 1/2 -> enqueue {side,qty,src}; net_pos updated the same edge (wraps mod 2^16).
//  - other side -> consumed, not enqueued, net_pos unchanged, drop_pulse next cycle.
//  - qty 0 is legal and is enqueued.
//  Issue FSM:
//  - IDLE: FIFO non-empty -> ISSUE; registered head loaded onto ord_*; ord_valid=1 next cycle.
//  - ISSUE: ord_valid and ord_* held stable until ord_ready. On handshake, pop; go to GAP,
//    loading counter=MIN_GAP; if MIN_GAP=0, go to IDLE instead.
//  - GAP: ord_valid=0; counter decrements; at 1 go to IDLE.
//  - Latency: empty FIFO, enqueue at edge N -> ord_valid high after edge N+1.
//  - Simultaneous enqueue and dequeue: count unchanged. Pointers wrap mod DEPTH.
//  - ord_ready while ord_valid=0 is ignored.
//  rst_n low mid-operation: immediate clear; queued orders lost; net_pos -> 0.
// CONFIGURATION
//  PIVOTA_POS_LIMIT_EN defined: a legal order whose post-update |net_pos| > POS_LIMIT is
//  consumed (src_ready still high), not enqueued, net_pos unchanged, reject_pulse next cycle.
//  PIVOTA_POS_LIMIT_EN undefined: no limit check; reject_pulse tied 0; POS_LIMIT unused.
// TESTING
//  1. Reset: rst_n=0 -> all outputs 0; release, no src_valid -> ord_valid stays 0.
//  2. Src0 buy qty5 at edge N, ord_ready=1 -> ord_valid at N+1 (side1 qty5 src0);
//     net_pos=5; 3 GAP cycles follow.
//  3. Both sources valid for 4 cycles -> grants 0,1,0,1; issue order preserved;
//     src1 sell qty3 -> net_pos decrements 3.
//  4. ord_ready=0, 17 orders offered -> fifo_count=16, src_ready=0;
//     ord_* stable throughout; ord_ready=1 drains in order.
//  5. side=7 qty2 -> drop_pulse one cycle, fifo_count and net_pos unchanged.
//  6. Macro on, POS_LIMIT=64, net_pos=60, buy qty5 -> reject_pulse, net_pos stays 60;
//     macro off -> net_pos=65.

Source files
------------

// File: rtl/pivota_order_scheduler_if.sv
// Order-entry bus: strategy-side request handshakes plus the single exchange-side issue port.
// The scheduler uses the slave modport; the strategy/exchange side uses master.
interface pivota_order_scheduler_if #(
   parameter int NUM_SRC = 2
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]       src_valid;
   logic [NUM_SRC-1:0]       src_ready;
   logic [NUM_SRC-1:0][3:0]  src_side;
   logic [NUM_SRC-1:0][3:0]  src_qty;
   logic                     ord_valid;
   logic                     ord_ready;
   logic [3:0]               ord_side;
   logic [3:0]               ord_qty;
   logic [SRC_W-1:0]         ord_src;

   modport master (
      output src_valid, src_side, src_qty, ord_ready,
      input  src_ready, ord_valid, ord_side, ord_qty, ord_src
   );

   modport slave (
      input  src_valid, src_side, src_qty, ord_ready,
      output src_ready, ord_valid, ord_side, ord_qty, ord_src
   );
endinterface

// File: rtl/pivota_order_scheduler.sv
// Round-robin order arbiter feeding a FIFO, with a gap-enforcing issue FSM and net-position tracking.
// Optional position-limit rejection is enabled by defining PIVOTA_POS_LIMIT_EN.
module pivota_order_scheduler #(
   parameter int NUM_SRC   = 2,
   parameter int DEPTH     = 16,
   parameter int MIN_GAP   = 3,
   parameter int POS_LIMIT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pivota_order_scheduler_if.slave  bus,
   output logic signed [15:0]       net_pos,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     drop_pulse,
   output logic                     reject_pulse
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int GW    = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

   typedef struct packed {
      logic [3:0]       side;
      logic [3:0]       qty;
      logic [SRC_W-1:0] src;
   } ord_t;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t             state_q, state_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic [SRC_W-1:0]   rr_q, rr_d;
   logic [AW-1:0]      wr_q, rd_q;
   logic [CW-1:0]      count_q, count_d;
   logic signed [15:0] pos_q, new_pos;
   ord_t               ord_q;
   ord_t               mem [DEPTH];
   logic               drop_q, reject_q;

   logic               gnt_vld;
   logic [SRC_W-1:0]   gnt_idx;
   logic [SRC_W:0]     idx;
   logic [NUM_SRC-1:0] ready;
   logic               xfer, legal, limit_hit, enq, pop, load;
   logic [3:0]         sel_side, sel_qty;

   // First valid source at or after rr_q, wrapping around.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         idx = {1'b0, rr_q} + (SRC_W+1)'(i);
         if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
         if (!gnt_vld && bus.src_valid[idx[SRC_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx[SRC_W-1:0];
         end
      end
   end

   // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
   always_comb begin
      ready = '0;
      if (gnt_vld && (count_q < CW'(DEPTH))) ready[gnt_idx] = 1'b1;
   end

   assign bus.src_ready = ready;
   assign xfer     = |ready;
   assign sel_side = bus.src_side[gnt_idx];
   assign sel_qty  = bus.src_qty[gnt_idx];
   assign legal    = (sel_side == 4'd1) || (sel_side == 4'd2);
   assign new_pos  = (sel_side == 4'd1) ? pos_q + $signed({12'd0, sel_qty})
                                        : pos_q - $signed({12'd0, sel_qty});

`ifdef PIVOTA_POS_LIMIT_EN
   logic [16:0] pos_ext, pos_abs;
   assign pos_ext   = {new_pos[15], new_pos};
   assign pos_abs   = pos_ext[16] ? (17'd0 - pos_ext) : pos_ext;
   assign limit_hit = legal && (pos_abs > 17'(POS_LIMIT));
`else
   logic unused_pos_limit;
   assign limit_hit        = 1'b0;
   assign unused_pos_limit = (POS_LIMIT != 0);
`endif

   assign enq     = xfer && legal && !limit_hit;
   assign pop     = (state_q == ISSUE) && bus.ord_ready;
   assign count_d = count_q + CW'(enq) - CW'(pop);

   always_comb begin
      rr_d = rr_q;
      if (xfer) rr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      load    = 1'b0;
      case (state_q)
         IDLE: if (count_q != '0) begin
            state_d = ISSUE;
            load    = 1'b1;
         end
         ISSUE: if (bus.ord_ready) begin
            if (MIN_GAP == 0) state_d = IDLE;
            else begin
               state_d = GAP;
               gap_d   = GW'(MIN_GAP);
            end
         end
         GAP: begin
            gap_d = gap_q - 1'b1;
            if (gap_q <= GW'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gap_q    <= '0;
         rr_q     <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         count_q  <= '0;
         pos_q    <= '0;
         ord_q    <= '0;
         drop_q   <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         rr_q     <= rr_d;
         count_q  <= count_d;
         drop_q   <= xfer && !legal;
         reject_q <= xfer && legal && limit_hit;
         if (enq) begin
            wr_q  <= wr_q + 1'b1;
            pos_q <= new_pos;
         end
         if (pop)  rd_q  <= rd_q + 1'b1;
         if (load) ord_q <= mem[rd_q];
      end
   end

   always_ff @(posedge clk) begin
      if (enq) mem[wr_q] <= '{side: sel_side, qty: sel_qty, src: gnt_idx};
   end

   assign bus.ord_valid = (state_q == ISSUE);
   assign bus.ord_side  = ord_q.side;
   assign bus.ord_qty   = ord_q.qty;
   assign bus.ord_src   = ord_q.src;
   assign net_pos       = pos_q;
   assign fifo_count    = count_q;
   assign drop_pulse    = drop_q;
   assign reject_pulse  = reject_q;
endmodule

// File: tb/tb_pivota_order_scheduler.sv
// Directed bench for pivota_order_scheduler: reset, latency/gap, round-robin, full FIFO,
// illegal side drop, position accounting and mid-operation reset.
module tb_pivota_order_scheduler;
   logic               clk;
   logic               rst_n;
   logic signed [15:0] net_pos;
   logic [4:0]         fifo_count;
   logic               drop_pulse, reject_pulse;
   logic signed [15:0] exp_pos;
   int                 tests, fails, n;

   pivota_order_scheduler_if #(.NUM_SRC(2)) bus ();

   pivota_order_scheduler #(.NUM_SRC(2), .DEPTH(16), .MIN_GAP(3), .POS_LIMIT(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .net_pos      (net_pos),
      .fifo_count   (fifo_count),
      .drop_pulse   (drop_pulse),
      .reject_pulse (reject_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int maxc, output int cyc);
      cyc = 0;
      while (bus.ord_valid !== 1'b1 && cyc < maxc) begin
         step();
         cyc++;
      end
      tests++;
      assert (bus.ord_valid === 1'b1) else begin
         fails++;
         $error("FAIL wait_valid: observed timeout after %0d cycles expected ord_valid", cyc);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      tests = 0; fails = 0; exp_pos = '0;
      rst_n = 1'b0;
      bus.src_valid = '0; bus.src_side = '0; bus.src_qty = '0; bus.ord_ready = 1'b0;

      // Reset state
      #3;
      check("rst_ord_valid", 32'(bus.ord_valid), 32'd0);
      check("rst_ord_side", 32'(bus.ord_side), 32'd0);
      check("rst_ord_qty", 32'(bus.ord_qty), 32'd0);
      check("rst_ord_src", 32'(bus.ord_src), 32'd0);
      check("rst_src_ready", 32'(bus.src_ready), 32'd0);
      check("rst_net_pos", {16'h0, net_pos}, 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_drop", 32'(drop_pulse), 32'd0);
      check("rst_reject", 32'(reject_pulse), 32'd0);
      #19 rst_n = 1'b1;
      step(); step(); step();
      check("idle_ord_valid", 32'(bus.ord_valid), 32'd0);

      // Single buy: latency, net_pos and gap
      bus.ord_ready = 1'b1;
      bus.src_valid = 2'b01; bus.src_side[0] = 4'd1; bus.src_qty[0] = 4'd5;
      #1 check("t2_src_ready", 32'(bus.src_ready), 32'b01);
      step();
      bus.src_valid = '0;
      check("t2_count_N", 32'(fifo_count), 32'd1);
      check("t2_net_pos", {16'h0, net_pos}, 32'd5);
      check("t2_valid_N", 32'(bus.ord_valid), 32'd0);
      step();
      check("t2_valid_N1", 32'(bus.ord_valid), 32'd1);
      check("t2_side", 32'(bus.ord_side), 32'd1);
      check("t2_qty", 32'(bus.ord_qty), 32'd5);
      check("t2_src", 32'(bus.ord_src), 32'd0);
      for (int g = 0; g < 4; g++) begin
         step();
         check("t2_gap_valid", 32'(bus.ord_valid), 32'd0);
      end
      check("t2_count_end", 32'(fifo_count), 32'd0);

      // Round-robin between two sources
      do_reset();
      bus.ord_ready = 1'b0;
      bus.src_valid = 2'b11;
      bus.src_side[0] = 4'd1; bus.src_qty[0] = 4'd2;
      bus.src_side[1] = 4'd2; bus.src_qty[1] = 4'd3;
      for (int k = 0; k < 4; k++) begin
         #1 check("t3_grant", 32'(bus.src_ready), (k % 2 == 1) ? 32'b10 : 32'b01);
         step();
      end
      bus.src_valid = '0;
      check("t3_count", 32'(fifo_count), 32'd4);
      check("t3_net_pos", {16'h0, net_pos}, 32'h0000_FFFE);
      check("t3_valid", 32'(bus.ord_valid), 32'd1);
      bus.ord_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            wait_valid(10, n);
            check("t3_gap_len", 32'(n), 32'd4);
         end
         check("t3_ord_src", 32'(bus.ord_src), 32'(k % 2));
         check("t3_ord_side", 32'(bus.ord_side), (k % 2 == 1) ? 32'd2 : 32'd1);
         check("t3_ord_qty", 32'(bus.ord_qty), (k % 2 == 1) ? 32'd3 : 32'd2);
         step();
      end
      check("t3_count_end", 32'(fifo_count), 32'd0);

      // Fill the FIFO with 17 offers while the exchange stalls
      exp_pos = -16'sd2;
      bus.ord_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus.src_valid   = 2'b01;
         bus.src_side[0] = (i % 2 == 0) ? 4'd1 : 4'd2;
         bus.src_qty[0]  = 4'(i);
         #1 check("t4_ready", 32'(bus.src_ready), (i < 16) ? 32'b01 : 32'b00);
         if (i < 16) begin
            if (i % 2 == 0) exp_pos = exp_pos + 16'(i);
            else            exp_pos = exp_pos - 16'(i);
            step();
         end
      end
      check("t4_count_full", 32'(fifo_count), 32'd16);
      check("t4_net_pos", {16'h0, net_pos}, {16'h0, exp_pos});
      for (int h = 0; h < 3; h++) begin
         check("t4_hold_valid", 32'(bus.ord_valid), 32'd1);
         check("t4_hold_qty", 32'(bus.ord_qty), 32'd0);
         check("t4_hold_side", 32'(bus.ord_side), 32'd1);
         check("t4_hold_ready", 32'(bus.src_ready), 32'd0);
         step();
      end
      bus.ord_ready = 1'b1;
      #1 check("t4_full_deq_ready", 32'(bus.src_ready), 32'd0);
      step();
      bus.src_valid = '0;
      check("t4_count_15", 32'(fifo_count), 32'd15);
      for (int i = 1; i < 16; i++) begin
         wait_valid(10, n);
         check("t4_drain_qty", 32'(bus.ord_qty), 32'(i));
         check("t4_drain_side", 32'(bus.ord_side), (i % 2 == 1) ? 32'd2 : 32'd1);
         step();
      end
      check("t4_count_end", 32'(fifo_count), 32'd0);

      // Illegal side is consumed and dropped
      step(); step();
      bus.src_valid = 2'b01; bus.src_side[0] = 4'd7; bus.src_qty[0] = 4'd2;
      #1 check("t5_ready", 32'(bus.src_ready), 32'b01);
      step();
      bus.src_valid = '0;
      check("t5_drop", 32'(drop_pulse), 32'd1);
      check("t5_count", 32'(fifo_count), 32'd0);
      check("t5_net_pos", {16'h0, net_pos}, {16'h0, exp_pos});
      step();
      check("t5_drop_clear", 32'(drop_pulse), 32'd0);
      check("t5_valid", 32'(bus.ord_valid), 32'd0);

      // Position limit boundary
      do_reset();
      bus.ord_ready = 1'b0;
      bus.src_valid = 2'b01; bus.src_side[0] = 4'd1; bus.src_qty[0] = 4'd15;
      for (int i = 0; i < 4; i++) begin
         #1 check("t6_ready", 32'(bus.src_ready), 32'b01);
         step();
      end
      check("t6_net_pos_60", {16'h0, net_pos}, 32'd60);
      bus.src_qty[0] = 4'd5;
      #1 check("t6_ready_over", 32'(bus.src_ready), 32'b01);
      step();
      bus.src_valid = '0;
`ifdef PIVOTA_POS_LIMIT_EN
      check("t6_net_pos", {16'h0, net_pos}, 32'd60);
      check("t6_reject", 32'(reject_pulse), 32'd1);
      check("t6_count", 32'(fifo_count), 32'd4);
`else
      check("t6_net_pos", {16'h0, net_pos}, 32'd65);
      check("t6_reject", 32'(reject_pulse), 32'd0);
      check("t6_count", 32'(fifo_count), 32'd5);
`endif
      step();
      check("t6_reject_clear", 32'(reject_pulse), 32'd0);
      check("t6_valid", 32'(bus.ord_valid), 32'd1);

      // Asynchronous reset mid-operation
      rst_n = 1'b0;
      #1;
      check("t7_valid", 32'(bus.ord_valid), 32'd0);
      check("t7_count", 32'(fifo_count), 32'd0);
      check("t7_net_pos", {16'h0, net_pos}, 32'd0);
      check("t7_qty", 32'(bus.ord_qty), 32'd0);
      rst_n = 1'b1;
      step(); step();
      check("t7_valid_after", 32'(bus.ord_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
